rgb_pwm_sequencer: RTL and testbench



---
 rtl/rgb_pwm_sequencer_pkg.sv | 9 +
 rtl/rgb_pwm_sequencer_chan.sv | 38 +++
 rtl/rgb_pwm_sequencer.sv | 86 ++++++++
 tb/tb_rgb_pwm_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_sequencer_pkg.sv
// Shared helpers for the RGB PWM colour sequencer.
package rgb_pwm_sequencer_pkg;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_chan.sv
// One LED channel: active-duty register updated only at period end, plus the output compare.
// RGB_SEQ_FADE_EN: duty slews one LSB per period toward the target instead of switching.
module rgb_pwm_sequencer_chan #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                period_end,
  input  logic [PWM_BITS-1:0] duty_tgt,
  output logic                pwm
);

  logic [PWM_BITS-1:0] duty_act;
  logic [PWM_BITS-1:0] duty_nxt;

`ifdef RGB_SEQ_FADE_EN
  always_comb begin
    duty_nxt = duty_act;
    if (duty_act < duty_tgt)      duty_nxt = duty_act + 1'b1;
    else if (duty_act > duty_tgt) duty_nxt = duty_act - 1'b1;
  end
`else
  assign duty_nxt = duty_tgt;
`endif

  // Duty only moves on the period boundary, so a period is never split.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (period_end) duty_act <= duty_nxt;
      pwm <= (pwm_cnt < duty_act);
    end
  end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Steps through a writable palette of per-channel PWM duties, one step every STEP_CYCLES clocks.
// Build option RGB_SEQ_FADE_EN turns colour changes into one-LSB-per-period fades.
module rgb_pwm_sequencer
  import rgb_pwm_sequencer_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int PWM_BITS    = 8,
  parameter int NUM_STEPS   = 3,
  parameter int STEP_CYCLES = 6000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       wr_en,
  input  logic [cw(NUM_STEPS)-1:0]   wr_addr,
  input  logic [cw(NUM_CH)-1:0]      wr_ch,
  input  logic [PWM_BITS-1:0]        wr_data,
  output logic [NUM_CH-1:0]          pwm,
  output logic [cw(NUM_STEPS)-1:0]   step_idx,
  output logic                       step_stb
);

  localparam int SW = cw(NUM_STEPS);
  localparam int TW = cw(STEP_CYCLES);
  localparam logic [PWM_BITS-1:0] PMAX   = '1;
  localparam logic [TW-1:0]       T_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [SW-1:0]       S_LAST = SW'(NUM_STEPS - 1);

  logic [NUM_STEPS-1:0][NUM_CH-1:0][PWM_BITS-1:0] pal;
  logic [NUM_CH-1:0][PWM_BITS-1:0]                tgt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [TW-1:0]       timer;
  logic                period_end;
  logic                advance;
  logic                wr_ok;

  assign period_end = (pwm_cnt == PMAX - 1'b1);
  assign advance    = run && (timer == T_LAST);
  assign wr_ok      = wr_en && (32'(wr_addr) < NUM_STEPS) && (32'(wr_ch) < NUM_CH);
  assign tgt        = pal[step_idx];

  // PWM period is PMAX clocks: counter runs 0..PMAX-1 so duty PMAX is solid on.
  always_ff @(posedge clk) begin
    if (reset || period_end) pwm_cnt <= '0;
    else                     pwm_cnt <= pwm_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer    <= '0;
      step_idx <= '0;
      step_stb <= 1'b0;
    end else begin
      step_stb <= advance;
      if (advance) begin
        timer    <= '0;
        step_idx <= (step_idx == S_LAST) ? '0 : step_idx + 1'b1;
      end else if (run) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Default palette walks the channels in order: step k lights channel k mod NUM_CH.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_STEPS; k++)
        for (int c = 0; c < NUM_CH; c++)
          pal[k][c] <= (c == k % NUM_CH) ? PMAX : '0;
    end else if (wr_ok) begin
      pal[wr_addr][wr_ch] <= wr_data;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rgb_pwm_sequencer_chan #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .pwm_cnt    (pwm_cnt),
      .period_end (period_end),
      .duty_tgt   (tgt[c]),
      .pwm        (pwm[c])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer with P=7, 3 steps, 50 clocks per step.
module tb_rgb_pwm_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [1:0] wr_ch = '0;
  logic [2:0] wr_data = '0;
  logic [2:0] pwm;
  logic [1:0] step_idx;
  logic       step_stb;

  int tests = 0, fails = 0;
  int n = 0, stb_cnt = 0, stb_last = 0;
  int r, g, b, s;
  logic [2:0] acc;
  logic       ok;

  rgb_pwm_sequencer #(
    .NUM_CH(3), .PWM_BITS(3), .NUM_STEPS(3), .STEP_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_ch(wr_ch), .wr_data(wr_data), .pwm(pwm), .step_idx(step_idx), .step_stb(step_stb)
  );

  always #5 clk = ~clk;

  // n counts rising edges since the last reset release; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk); #1;
    n++;
    if (step_stb === 1'b1) begin stb_cnt++; stb_last = n; end
  endtask

  task automatic tick_to(input int t);
    while (n < t) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full PWM period of high-counts per channel; call with n a multiple of 7.
  task automatic period();
    r = 0; g = 0; b = 0;
    repeat (7) begin
      tick();
      r += int'(pwm[0]); g += int'(pwm[1]); b += int'(pwm[2]);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_idx", 32'(step_idx), 0);
    chk("rst_stb", 32'(step_stb), 0);
    reset = 1'b0; run = 1'b1; n = 0; stb_cnt = 0;

`ifdef RGB_SEQ_FADE_EN
    // Red ramps up from dark, one LSB per period.
    for (int m = 0; m < 8; m++) begin
      period();
      chk("fade_up_red", 32'(r), 32'(m));
      chk("fade_up_green", 32'(g), 0);
    end
    // Step 1 at clk 50: red fades out while green fades in.
    for (int j = 0; j < 7; j++) begin
      period();
      chk("fade_red_down", 32'(r), 32'(6 - j));
      chk("fade_green_up", 32'(g), 32'(1 + j));
    end
`else
    // Test 1: dark first period, then red solid, step change at clk 50.
    acc = '0;
    repeat (7) begin tick(); acc |= pwm; end
    chk("dark_first_period", 32'(acc), 0);
    ok = 1'b1;
    while (n < 49) begin tick(); if (pwm !== 3'b001) ok = 1'b0; end
    chk("red_steady", 32'(ok), 1);
    chk("stb_before_50", 32'(step_stb), 0);
    tick();
    chk("stb_at_50", 32'(step_stb), 1);
    chk("idx_at_50", 32'(step_idx), 1);
    tick();
    chk("stb_one_cycle", 32'(step_stb), 0);
    chk("red_until_boundary", 32'(pwm), 32'(3'b001));
    tick_to(56);
    period();
    chk("green_r", 32'(r), 0);
    chk("green_g", 32'(g), 7);
    chk("green_b", 32'(b), 0);

    // Test 2: wrap through blue back to step 0.
    tick_to(100);
    chk("stb_at_100", 32'(step_stb), 1);
    chk("idx_at_100", 32'(step_idx), 2);
    tick_to(105);
    period();
    chk("blue_b", 32'(b), 7);
    chk("blue_rg", 32'(r + g), 0);
    tick_to(150);
    chk("stb_count", 32'(stb_cnt), 3);
    chk("stb_last", 32'(stb_last), 150);
    chk("idx_wrap", 32'(step_idx), 0);

    // Test 3: red=3 written mid-period, takes effect at the next boundary only.
    tick_to(154);
    r = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin wr_en = 1'b1; wr_addr = 2'd0; wr_ch = 2'd0; wr_data = 3'd3; end
      else wr_en = 1'b0;
      tick();
      r += int'(pwm[0]);
    end
    chk("red_before_boundary", 32'(r), 7);
    period();
    chk("red_duty3", 32'(r), 3);
    chk("green_duty0", 32'(g), 0);

    // Test 4: freeze at timer=20 for 100 clocks; PWM keeps running.
    tick_to(170);
    run = 1'b0;
    s = stb_cnt;
    tick_to(175);
    period();
    chk("pwm_while_frozen", 32'(r), 3);
    tick_to(270);
    chk("frozen_no_stb", 32'(stb_cnt), 32'(s));
    chk("frozen_idx", 32'(step_idx), 0);
    run = 1'b1;
    tick_to(299);
    chk("resume_idx_299", 32'(step_idx), 0);
    tick();
    chk("resume_stb_300", 32'(step_stb), 1);
    chk("resume_idx_300", 32'(step_idx), 1);

    // Test 5: out-of-range writes are dropped; reset restores defaults.
    wr_en = 1'b1; wr_addr = 2'd3; wr_ch = 2'd1; wr_data = 3'd0;
    tick();
    wr_addr = 2'd1; wr_ch = 2'd3; wr_data = 3'd5;
    tick();
    wr_en = 1'b0;
    tick_to(308);
    period();
    chk("inv_wr_r", 32'(r), 0);
    chk("inv_wr_g", 32'(g), 7);
    tick_to(325);
    reset = 1'b1;
    tick();
    chk("midrst_pwm", 32'(pwm), 0);
    chk("midrst_idx", 32'(step_idx), 0);
    chk("midrst_stb", 32'(step_stb), 0);
    reset = 1'b0; n = 0; stb_cnt = 0;
    acc = '0;
    repeat (7) begin tick(); acc |= pwm; end
    chk("midrst_dark", 32'(acc), 0);
    period();
    chk("default_red_restored", 32'(r), 7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
